// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared widths and FSM encodings for the RAM arbiter.
// Imported by ram_arbiter_if, ram_arb_pick and ram_arbiter.
package ram_arb_pkg;

    localparam int RAM_AW = 8;
    localparam int RAM_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: requester ports 0/1 plus the single-port RAM side.
// master = requesters and RAM model, slave = the arbiter.
interface ram_arbiter_if;
    import ram_arb_pkg::*;

    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic              lock0;
    logic              lock1;
    logic [RAM_AW-1:0] addr0;
    logic [RAM_AW-1:0] addr1;
    logic [RAM_DW-1:0] wdata0;
    logic [RAM_DW-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [RAM_DW-1:0] rdata0;
    logic [RAM_DW-1:0] rdata1;
    logic              ram_we;
    logic [RAM_AW-1:0] ram_addr;
    logic [RAM_DW-1:0] ram_din;
    logic [RAM_DW-1:0] ram_dout;

    modport master (
        output req0, req1, we0, we1, lock0, lock1,
        output addr0, addr1, wdata0, wdata1,
        output ram_dout,
        input  gnt0, gnt1, rvalid0, rvalid1,
        input  rdata0, rdata1,
        input  ram_we, ram_addr, ram_din
    );

    modport slave (
        input  req0, req1, we0, we1, lock0, lock1,
        input  addr0, addr1, wdata0, wdata1,
        input  ram_dout,
        output gnt0, gnt1, rvalid0, rvalid1,
        output rdata0, rdata1,
        output ram_we, ram_addr, ram_din
    );

endinterface

// File: rtl/ram_arb_pick.sv
// ram_arb_pick: combinational winner selection, at most one grant.
// RAM_ARB_RR_EN defined: ties round-robin; else port 0 wins ties.
module ram_arb_pick
    import ram_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  arb_state_t i_state,
    input  logic       i_last,
    input  logic       i_lim,
    output logic       o_gnt0,
    output logic       o_gnt1
);

    logic w_keep0;
    logic w_keep1;
    logic w_tie1;

    assign w_keep0 = (i_state == ST_OWN0) && i_req0
                     && (!i_lim || !i_req1);
    assign w_keep1 = (i_state == ST_OWN1) && i_req1
                     && (!i_lim || !i_req0);

`ifdef RAM_ARB_RR_EN
    assign w_tie1 = ~i_last;
`else
    // Fixed priority still has to hand over when port 0 hit its limit.
    logic w_unused_last;
    assign w_unused_last = i_last;
    assign w_tie1 = (i_state == ST_OWN0) && i_lim;
`endif

    // Owner keeps first, then a lone requester, then the tie rule.
    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (w_keep0) begin
            o_gnt0 = 1'b1;
        end else if (w_keep1) begin
            o_gnt1 = 1'b1;
        end else if (i_req0 && i_req1) begin
            o_gnt0 = ~w_tie1;
            o_gnt1 = w_tie1;
        end else begin
            o_gnt0 = i_req0;
            o_gnt1 = i_req1;
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one 256x16 single-port RAM between two ports.
// Optional macro RAM_ARB_RR_EN selects round-robin tie breaking.
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
)
(
    input  logic          clk,
    input  logic          rst_n,
    ram_arbiter_if.slave  bus
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAXC = CW'(MAX_BURST);

    arb_state_t    r_state;
    arb_state_t    w_state_nxt;
    logic          r_last;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_lim;
    logic          w_same;

    assign w_lim = (r_cnt >= MAXC);

    ram_arb_pick u_pick (
        .i_req0  (bus.req0),
        .i_req1  (bus.req1),
        .i_state (r_state),
        .i_last  (r_last),
        .i_lim   (w_lim),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    // State, last winner, burst count and read strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_last    <= 1'b1;
            r_cnt     <= '0;
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rvalid0 <= w_gnt0 & ~bus.we0;
            r_rvalid1 <= w_gnt1 & ~bus.we1;
            if (w_gnt0 || w_gnt1) begin
                r_last <= w_gnt1;
            end
        end
    end

    // Next ownership and saturating burst count.
    always_comb begin
        w_state_nxt = ST_IDLE;
        if (w_gnt0 && bus.lock0) begin
            w_state_nxt = ST_OWN0;
        end else if (w_gnt1 && bus.lock1) begin
            w_state_nxt = ST_OWN1;
        end
        w_same = (w_gnt0 && r_state == ST_OWN0)
              || (w_gnt1 && r_state == ST_OWN1);
        w_cnt_nxt = '0;
        if (w_state_nxt != ST_IDLE) begin
            if (!w_same) begin
                w_cnt_nxt = CW'(1);
            end else if (w_lim) begin
                w_cnt_nxt = r_cnt;
            end else begin
                w_cnt_nxt = r_cnt + CW'(1);
            end
        end
    end

    // RAM mux and per-port outputs; idle cycles present port 0.
    always_comb begin
        bus.gnt0     = w_gnt0;
        bus.gnt1     = w_gnt1;
        bus.ram_we   = 1'b0;
        bus.ram_addr = bus.addr0;
        bus.ram_din  = bus.wdata0;
        if (w_gnt1) begin
            bus.ram_we   = bus.we1;
            bus.ram_addr = bus.addr1;
            bus.ram_din  = bus.wdata1;
        end else if (w_gnt0) begin
            bus.ram_we   = bus.we0;
        end
        bus.rvalid0 = r_rvalid0;
        bus.rvalid1 = r_rvalid1;
        bus.rdata0  = r_rvalid0 ? bus.ram_dout : '0;
        bus.rdata1  = r_rvalid1 ? bus.ram_dout : '0;
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter with a RAM model.
// Build with or without RAM_ARB_RR_EN; tie expectations follow it.
module tb_ram_arbiter;

    localparam int MB = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    ram_arbiter_if bus();

    ram_arbiter #(.MAX_BURST(MB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] init_word(input int a);
        if (a == 'h10) return 16'hBEEF;
        return 16'(32'hA500 + a);
    endfunction

    logic [15:0] mem [256];

    // RAM model: write-through array, registered read port.
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            bus.ram_dout <= '0;
        end else begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
            bus.ram_dout <= mem[bus.ram_addr];
        end
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] shadow [256];
    logic [15:0] q0 [$];
    logic [15:0] q1 [$];
    bit pend0 = 0;
    bit pend1 = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic l,
                          input logic [7:0] a, input logic [15:0] d);
        bus.req0 = r; bus.we0 = w; bus.lock0 = l;
        bus.addr0 = a; bus.wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l,
                          input logic [7:0] a, input logic [15:0] d);
        bus.req1 = r; bus.we1 = w; bus.lock1 = l;
        bus.addr1 = a; bus.wdata1 = d;
    endtask

    task automatic do_reset();
        drive0(0, 0, 0, 8'h00, 16'h0000);
        drive1(0, 0, 0, 8'h00, 16'h0000);
        rst_n = 1'b0;
        pend0 = 0;
        pend1 = 0;
        q0.delete();
        q1.delete();
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst.gnt", {bus.gnt1, bus.gnt0}, 0);
        chk("rst.rvalid", {bus.rvalid1, bus.rvalid0}, 0);
        chk("rst.rdata", {bus.rdata1, bus.rdata0}, 0);
        chk("rst.ram", {bus.ram_we, bus.ram_addr, bus.ram_din}, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // One cycle: check grants and RAM mux, retire last cycle's reads,
    // then queue the data expected from this cycle's granted reads.
    task automatic step(input string tag, input logic e0, input logic e1);
        @(negedge clk);
        chk({tag, ".gnt0"}, bus.gnt0, e0);
        chk({tag, ".gnt1"}, bus.gnt1, e1);
        if (e1) begin
            chk({tag, ".ram1"}, {bus.ram_we, bus.ram_addr},
                {bus.we1, bus.addr1});
            if (bus.we1) chk({tag, ".din1"}, bus.ram_din, bus.wdata1);
        end else if (e0) begin
            chk({tag, ".ram0"}, {bus.ram_we, bus.ram_addr},
                {bus.we0, bus.addr0});
            if (bus.we0) chk({tag, ".din0"}, bus.ram_din, bus.wdata0);
        end else begin
            chk({tag, ".ram_we"}, bus.ram_we, 0);
        end
        chk({tag, ".rvalid0"}, bus.rvalid0, pend0);
        chk({tag, ".rvalid1"}, bus.rvalid1, pend1);
        if (pend0 && q0.size() > 0)
            chk({tag, ".rdata0"}, bus.rdata0, q0.pop_front());
        else
            chk({tag, ".rdata0_0"}, bus.rdata0, 0);
        if (pend1 && q1.size() > 0)
            chk({tag, ".rdata1"}, bus.rdata1, q1.pop_front());
        else
            chk({tag, ".rdata1_0"}, bus.rdata1, 0);
        pend0 = e0 && !bus.we0;
        pend1 = e1 && !bus.we1;
        if (pend0) q0.push_back(shadow[bus.addr0]);
        if (pend1) q1.push_back(shadow[bus.addr1]);
        if (e0 && bus.we0) shadow[bus.addr0] = bus.wdata0;
        if (e1 && bus.we1) shadow[bus.addr1] = bus.wdata1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic g0;

        // Single read of preloaded word.
        do_reset();
        drive0(1, 0, 0, 8'h10, 16'h0000);
        step("rd", 1, 0);
        drive0(0, 0, 0, 8'h00, 16'h0000);
        step("rd_ret", 0, 0);

        // Both requesting, no lock: tie sequence.
        do_reset();
        drive0(1, 0, 0, 8'h10, 16'h0000);
        drive1(1, 0, 0, 8'h11, 16'h0000);
        for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_RR_EN
            g0 = (i % 2 == 0);
`else
            g0 = 1'b1;
`endif
            step("tie", g0, !g0);
        end
        drive0(0, 0, 0, 8'h00, 16'h0000);
        drive1(0, 0, 0, 8'h00, 16'h0000);
        step("tie_ret", 0, 0);

        // Write on port 1, read back on port 0 the next cycle.
        do_reset();
        drive1(1, 1, 0, 8'h20, 16'h1234);
        step("wr1", 0, 1);
        drive1(0, 0, 0, 8'h00, 16'h0000);
        drive0(1, 0, 0, 8'h20, 16'h0000);
        step("rd0", 1, 0);
        drive0(0, 0, 0, 8'h00, 16'h0000);
        step("rd0_ret", 0, 0);
        chk("raw.shadow", shadow[8'h20], 16'h1234);

        // Locked port 0 against requesting port 1: handover after MB.
        do_reset();
        drive0(1, 0, 1, 8'h30, 16'h0000);
        drive1(1, 0, 0, 8'h31, 16'h0000);
        for (int i = 0; i < MB; i++) step("burst0", 1, 0);
        step("handover", 0, 1);
        drive1(0, 0, 0, 8'h00, 16'h0000);
        step("reown0", 1, 0);
        drive0(0, 0, 0, 8'h00, 16'h0000);
        step("burst_ret", 0, 0);

        // Locked port 1 alone: no handover past the limit.
        do_reset();
        drive1(1, 0, 1, 8'h40, 16'h0000);
        for (int i = 0; i < MB + 3; i++) step("solo1", 0, 1);
        drive0(1, 0, 0, 8'h41, 16'h0000);
        step("sat_hand", 1, 0);
        drive0(0, 0, 0, 8'h00, 16'h0000);
        drive1(0, 0, 0, 8'h00, 16'h0000);
        step("solo_ret", 0, 0);

        // Reset right after a locked read grant: strobe drops at once.
        do_reset();
        drive0(1, 0, 1, 8'h10, 16'h0000);
        step("pre_rst", 1, 0);
        chk("pre_rst.rvalid0", bus.rvalid0, 1);
        drive0(0, 0, 0, 8'h00, 16'h0000);
        rst_n = 1'b0;
        #1;
        chk("mid_rst.rvalid0", bus.rvalid0, 0);
        chk("mid_rst.rdata0", bus.rdata0, 0);
        q0.delete();
        pend0 = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive0(1, 0, 0, 8'h12, 16'h0000);
        drive1(1, 0, 0, 8'h13, 16'h0000);
        step("post_rst", 1, 0);
        drive0(0, 0, 0, 8'h00, 16'h0000);
        drive1(0, 0, 0, 8'h00, 16'h0000);
        step("post_ret", 0, 0);

        chk("q0_drain", q0.size(), 0);
        chk("q1_drain", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-port 256x16 data RAM (`ram_md`) between two requesters, e.g. the CPU load/store unit on port 0 and a DMA/program loader on port 1. Each cycle it picks at most one requester, forwards that requester's address, write data and write enable to the RAM, and returns a read-data-valid strobe one cycle later. Optional lock lets a requester hold the RAM for back-to-back accesses, bounded by a burst limit to prevent starvation.

## Interface
- `MAX_BURST`, default 4: maximum consecutive locked grants to one port while the other port is requesting (≥1).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  access request; held until `gnt` for that port.
- `we0` / `we1`  in  1  1 = write, 0 = read; valid with `req`.
- `addr0` / `addr1`  in  8  word address.
- `wdata0` / `wdata1`  in  16  write data.
- `lock0` / `lock1`  in  1  request to keep ownership for the next access.
- `gnt0` / `gnt1`  out  1  access accepted this cycle (combinational).
- `rvalid0` / `rvalid1`  out  1  read data valid on `rdata` (registered).
- `rdata0` / `rdata1`  out  16  read data; 0 when `rvalid` low.
- `ram_we`  out  1  RAM write enable.
- `ram_addr`  out  8  RAM address.
- `ram_din`  out  16  RAM write data.
- `ram_dout`  in  16  RAM read data (1-cycle latency from address).

## Operation
- FSM states: IDLE, OWN0, OWN1. Registers: state, `last` (last granted port), `burst_cnt` (0..MAX_BURST, saturating), `rvalid0/1`.
- Winner selection each cycle:
  - In OWNx: x keeps the grant if `reqx` and (`burst_cnt` < MAX_BURST or other port not requesting).
  - Otherwise (IDLE, owner not requesting, or limit hit with other requesting): single requester wins; with both requesting, the port ≠ `last` wins (see Configuration).
  - No requests: no grant.
- Winner w: `gntw`=1, `ram_we`=`wew`, `ram_addr`=`addrw`, `ram_din`=`wdataw`. No winner: `ram_we`=0, `ram_addr`/`ram_din` driven from port 0 (don't-care but deterministic).
- Next state: grant with `lockw`=1 → OWNw; else IDLE. `last` ← w on every grant.
- `burst_cnt`: set to 1 on grant to a port different from the current owner or from IDLE; incremented (saturating) on a repeated grant to the owner; cleared to 0 in IDLE.
- Read return: `rvalidx` ← `gntx` & ~`wex`; `rdatax` = `rvalidx` ? `ram_dout` : 0.
- Requester rule: `we/addr/wdata/lock` stable while `req` high and ungranted; dropping `req` before grant is an abort, no side effect.
- Write and read in the same cycle is impossible (one grant per cycle); a read immediately after a write to the same address returns the new data.

## Timing
- Reset values: state IDLE, `last`=1 (port 0 wins first tie), `burst_cnt`=0, all `gnt`/`rvalid`=0, `rdata`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0 (outputs reflect no requests during reset).
- Grant latency 0 (same cycle as `req`); read data latency 1 cycle after grant.
- Throughput: one access per cycle; back-to-back reads pipeline.
- Reset mid-operation: `rvalid` clears asynchronously; an in-flight read is lost and must be reissued.

## Configuration
- `RAM_ARB_RR_EN` defined: ties resolved round-robin (port ≠ `last`).
- Undefined: fixed priority, port 0 wins every tie; lock and MAX_BURST behaviour unchanged (burst limit still forces handover to port 1).

## Structure
- Shared package `ram_arb_pkg`: `RAM_AW`=8, `RAM_DW`=16, state encodings `ST_IDLE`, `ST_OWN0`, `ST_OWN1`.
- One sub-module `ram_arb_pick`: combinational winner selection from reqs, state, `last`, `burst_cnt`, limit flag.

## Test plan
- Reset then `req0` read addr 0x10 (RAM holds 0xBEEF) → `gnt0` same cycle, `rvalid0`=1, `rdata0`=0xBEEF next cycle; `rvalid1`=0.
- Both request, no lock, 4 cycles, RR_EN → grants 0,1,0,1; without macro → 0,0,0,0.
- Port 1 writes 0x1234 to 0x20, then port 0 reads 0x20 next cycle → `rdata0`=0x1234.
- `lock0` held with `req0` continuous, `req1` asserted, MAX_BURST=4 → four `gnt0`, then `gnt1` on cycle 5.
- `lock1` held, `req0` low → `gnt1` every cycle beyond MAX_BURST, no handover.
- `rst_n` low cycle after read grant → `rvalid0`=0 immediately, state IDLE, first tie after release goes to port 0.
